instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 114 +++++++++++
 tb/tb_instr_fetch_queue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: a circular FIFO of instruction pairs fed by a
// single-outstanding fetch FSM, with branch redirect, flush and misaligned-target fixup.
module instr_fetch_queue #(
    parameter int               WORD     = 32,
    parameter int               FQ_DEPTH = 4,
    parameter logic [WORD-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                branch_taken,
    input  logic [WORD-1:0]     BTA,
    input  logic                dep_stall,
    output logic                imem_req,
    output logic [WORD-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [2*WORD-1:0]   imem_data,
    output logic [WORD-1:0]     instr1,
    output logic [WORD-1:0]     instr2,
    output logic                instr_valid,
    output logic [WORD-1:0]     PC
);

    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam logic [WORD-1:0] NOP = WORD'(32'h4020_0000);

    typedef struct packed {
        logic [WORD-1:0] pc;
        logic [WORD-1:0] i1;
        logic [WORD-1:0] i2;
    } fq_entry_t;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    fq_entry_t       mem [FQ_DEPTH];
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   count, count_after;
    logic [WORD-1:0] fetch_pc;
    logic            misalign;
    state_t          state, state_nxt;
    logic            push, pop;
    fq_entry_t       wr_entry;
    logic            unused_bta;

    assign unused_bta = ^BTA[1:0];

    // A redirect overrides any pop or push in the same cycle.
    assign pop         = (count != '0) && !dep_stall && !branch_taken;
    assign push        = (state == S_WAIT) && imem_ack && !branch_taken;
    assign count_after = count + CW'(push) - CW'(pop);

    always_comb begin
        wr_entry.pc = fetch_pc;
        wr_entry.i1 = misalign ? NOP : imem_data[2*WORD-1:WORD];
        wr_entry.i2 = imem_data[WORD-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (branch_taken || count < CW'(FQ_DEPTH)) state_nxt = S_REQ;
            S_REQ:   state_nxt = branch_taken ? S_REQ : S_WAIT;
            S_WAIT: begin
                // A redirect coinciding with the ack leaves nothing in flight, so skip DRAIN.
                if (branch_taken)  state_nxt = imem_ack ? S_REQ : S_DRAIN;
                else if (imem_ack) state_nxt = (count_after < CW'(FQ_DEPTH)) ? S_REQ : S_IDLE;
            end
            S_DRAIN: if (imem_ack) state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A request squashed by a same-cycle redirect is never issued, keeping one in flight at most.
    assign imem_req  = (state == S_REQ) && !branch_taken;
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            count    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            fetch_pc <= RESET_PC;
            misalign <= 1'b0;
        end else begin
            state <= state_nxt;
            if (branch_taken) begin
                count    <= '0;
                wptr     <= '0;
                rptr     <= '0;
                fetch_pc <= {BTA[WORD-1:3], 3'b000};
                misalign <= BTA[2];
            end else begin
                count <= count_after;
                if (push) begin
                    wptr     <= wptr + PW'(1);
                    fetch_pc <= fetch_pc + WORD'(8);
                    misalign <= 1'b0;
                end
                if (pop) rptr <= rptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_entry;
    end

    assign instr_valid = (count != '0);
    assign instr1      = instr_valid ? mem[rptr].i1 : '0;
    assign instr2      = instr_valid ? mem[rptr].i2 : '0;
    assign PC          = instr_valid ? mem[rptr].pc : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: cycle table for fetch/redirect, plus
// hand sequences for stall-fill, push/pop at full, wrap ordering, reset and flush.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_taken;
    logic [31:0] BTA;
    logic        dep_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [63:0] imem_data;
    logic [63:0] man_data;
    logic        use_auto;
    logic [31:0] instr1, instr2, PC;
    logic        instr_valid;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] NOP = 32'h4020_0000;

    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    function automatic logic [63:0] pair(input logic [31:0] a);
        return {w(a), w(a + 32'd4)};
    endfunction

    assign imem_data = use_auto ? pair(imem_addr) : man_data;

    instr_fetch_queue dut (
        .clk(clk), .reset(reset), .branch_taken(branch_taken), .BTA(BTA),
        .dep_stall(dep_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .instr1(instr1),
        .instr2(instr2), .instr_valid(instr_valid), .PC(PC)
    );

    typedef struct {
        logic        br;
        logic [31:0] bta;
        logic        st;
        logic        ack;
        logic [31:0] dat;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic        e_nop;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mkv(input logic br, input logic [31:0] bta, input logic st,
                                 input logic ack, input logic [31:0] dat, input logic e_req,
                                 input logic [31:0] e_addr, input logic e_vld,
                                 input logic [31:0] e_pc, input logic e_nop);
        vec_t v;
        v.br = br; v.bta = bta; v.st = st; v.ack = ack; v.dat = dat;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc; v.e_nop = e_nop;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic e_req, input logic [31:0] e_addr,
                           input logic e_vld, input logic [31:0] e_pc, input logic e_nop);
        chk({nm, ".imem_req"}, 64'(imem_req), 64'(e_req));
        chk({nm, ".imem_addr"}, 64'(imem_addr), 64'(e_addr));
        chk({nm, ".instr_valid"}, 64'(instr_valid), 64'(e_vld));
        if (e_vld) begin
            chk({nm, ".PC"}, 64'(PC), 64'(e_pc));
            chk({nm, ".instr1"}, 64'(instr1), 64'(e_nop ? NOP : w(e_pc)));
            chk({nm, ".instr2"}, 64'(instr2), 64'(w(e_pc + 32'd4)));
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic apply(input logic br, input logic [31:0] bta, input logic st,
                         input logic ack, input logic [31:0] dat);
        branch_taken = br; BTA = bta; dep_stall = st; imem_ack = ack; man_data = pair(dat);
        #1;
    endtask

    task automatic next_cyc;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0; use_auto = 1'b0;
        apply(0, 0, 0, 0, 0);
        next_cyc; next_cyc;
        reset = 1'b1;
    endtask

    initial begin
        int nreq;
        int npop;
        logic [31:0] exp_pc;

        // Fetch from reset with one idle WAIT cycle per ack, then redirect to 0x104 while in WAIT.
        tbl[0]  = mkv(0, 0,         0, 0, 0,         0, 32'h000, 0, 0, 0);
        tbl[1]  = mkv(0, 0,         0, 0, 0,         1, 32'h000, 0, 0, 0);
        tbl[2]  = mkv(0, 0,         0, 0, 0,         0, 32'h000, 0, 0, 0);
        tbl[3]  = mkv(0, 0,         0, 1, 32'h000,   0, 32'h000, 0, 0, 0);
        tbl[4]  = mkv(0, 0,         0, 0, 0,         1, 32'h008, 1, 32'h000, 0);
        tbl[5]  = mkv(0, 0,         0, 0, 0,         0, 32'h008, 0, 0, 0);
        tbl[6]  = mkv(0, 0,         0, 1, 32'h008,   0, 32'h008, 0, 0, 0);
        tbl[7]  = mkv(0, 0,         0, 0, 0,         1, 32'h010, 1, 32'h008, 0);
        tbl[8]  = mkv(0, 0,         0, 0, 0,         0, 32'h010, 0, 0, 0);
        tbl[9]  = mkv(0, 0,         0, 1, 32'h010,   0, 32'h010, 0, 0, 0);
        tbl[10] = mkv(0, 0,         0, 0, 0,         1, 32'h018, 1, 32'h010, 0);
        tbl[11] = mkv(1, 32'h104,   0, 0, 0,         0, 32'h018, 0, 0, 0);
        tbl[12] = mkv(0, 0,         0, 1, 32'h018,   0, 32'h100, 0, 0, 0);
        tbl[13] = mkv(0, 0,         0, 0, 0,         1, 32'h100, 0, 0, 0);
        tbl[14] = mkv(0, 0,         0, 1, 32'h100,   0, 32'h100, 0, 0, 0);
        tbl[15] = mkv(0, 0,         0, 0, 0,         1, 32'h108, 1, 32'h100, 1);
        tbl[16] = mkv(0, 0,         0, 1, 32'h108,   0, 32'h108, 0, 0, 0);
        tbl[17] = mkv(0, 0,         1, 0, 0,         1, 32'h110, 1, 32'h108, 0);

        reset = 1'b0; use_auto = 1'b0;
        apply(0, 0, 0, 0, 0);
        next_cyc; next_cyc;
        chk("rst.imem_req", 64'(imem_req), 64'd0);
        chk("rst.imem_addr", 64'(imem_addr), 64'd0);
        chk("rst.instr_valid", 64'(instr_valid), 64'd0);
        chk("rst.instr1", 64'(instr1), 64'd0);
        chk("rst.instr2", 64'(instr2), 64'd0);
        chk("rst.PC", 64'(PC), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i].br, tbl[i].bta, tbl[i].st, tbl[i].ack, tbl[i].dat);
            chk_out($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld,
                    tbl[i].e_pc, tbl[i].e_nop);
            next_cyc;
        end

        // Reset pulse while WAITing with a held entry, then a stale ack after release.
        apply(0, 0, 1, 0, 0);
        chk_out("prerst", 0, 32'h110, 1, 32'h108, 0);
        reset = 1'b0;
        #1;
        chk("midrst.imem_req", 64'(imem_req), 64'd0);
        chk("midrst.imem_addr", 64'(imem_addr), 64'd0);
        chk("midrst.instr_valid", 64'(instr_valid), 64'd0);
        chk("midrst.instr1", 64'(instr1), 64'd0);
        chk("midrst.PC", 64'(PC), 64'd0);
        next_cyc;
        reset = 1'b1;
        apply(0, 0, 0, 1, 32'h110);
        chk_out("rel0", 0, 32'h000, 0, 0, 0);
        next_cyc;
        apply(0, 0, 0, 0, 0);
        chk_out("rel1", 1, 32'h000, 0, 0, 0);
        next_cyc;
        apply(0, 0, 0, 1, 32'h000);
        chk_out("rel2", 0, 32'h000, 0, 0, 0);
        next_cyc;
        apply(0, 0, 0, 0, 0);
        chk_out("rel3", 1, 32'h008, 1, 32'h000, 0);

        // Stalled decode with memory always acking: exactly four fetches, head stays at 0x0.
        do_reset;
        use_auto = 1'b1;
        nreq = 0;
        for (int i = 0; i < 16; i++) begin
            apply(0, 0, 1, 1, 0);
            if (imem_req) nreq++;
            next_cyc;
        end
        apply(0, 0, 1, 1, 0);
        chk("fill.nreq", 64'(nreq), 64'd4);
        chk_out("fill", 0, 32'h020, 1, 32'h000, 0);
        next_cyc;

        // Pop once, refetch, then push and pop together: occupancy must stay at three.
        apply(0, 0, 0, 1, 0);
        chk_out("pp0", 0, 32'h020, 1, 32'h000, 0);
        next_cyc;
        apply(0, 0, 1, 1, 0);
        chk_out("pp1", 0, 32'h020, 1, 32'h008, 0);
        next_cyc;
        apply(0, 0, 1, 1, 0);
        chk_out("pp2", 1, 32'h020, 1, 32'h008, 0);
        next_cyc;
        apply(0, 0, 0, 1, 0);
        chk_out("pp3", 0, 32'h020, 1, 32'h008, 0);
        next_cyc;
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            apply(0, 0, 1, 1, 0);
            if (imem_req) nreq++;
            next_cyc;
        end
        apply(0, 0, 1, 1, 0);
        chk("pp.nreq", 64'(nreq), 64'd1);
        chk_out("pp4", 0, 32'h030, 1, 32'h010, 0);
        next_cyc;

        // Free-running drain: pairs emerge in address order across pointer wraps.
        exp_pc = 32'h010;
        npop = 0;
        for (int i = 0; i < 40; i++) begin
            apply(0, 0, 0, 1, 0);
            if (instr_valid) begin
                chk($sformatf("ord%0d.PC", npop), 64'(PC), 64'(exp_pc));
                chk($sformatf("ord%0d.instr1", npop), 64'(instr1), 64'(w(exp_pc)));
                exp_pc += 32'd8;
                npop++;
            end
            next_cyc;
        end
        chk("ord.npop_ge10", 64'(npop >= 10), 64'd1);

        // Fill again, then an aligned redirect flushes the full queue.
        for (int i = 0; i < 14; i++) begin
            apply(0, 0, 1, 1, 0);
            next_cyc;
        end
        apply(0, 0, 1, 1, 0);
        chk_out("fl0", 0, exp_pc + 32'd32, 1, exp_pc, 0);
        apply(1, 32'h200, 1, 1, 0);
        chk("fl1.imem_req", 64'(imem_req), 64'd0);
        next_cyc;
        apply(0, 0, 1, 1, 0);
        chk_out("fl2", 1, 32'h200, 0, 0, 0);
        next_cyc;
        apply(0, 0, 1, 1, 0);
        chk_out("fl3", 0, 32'h200, 0, 0, 0);
        next_cyc;
        apply(0, 0, 1, 1, 0);
        chk_out("fl4", 1, 32'h208, 1, 32'h200, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule
